// File: rtl/da_acc_engine.sv
// da_acc_engine: bit-serial distributed-arithmetic MAC over N_GRP coefficient LUTs, accumulating acc_len+1 sample sets.
// Define DA_SAT_EN to saturate the result to OUT_W bits; otherwise the result wraps.
module da_acc_engine #(
    parameter int N_GRP  = 2,
    parameter int GRP_SZ = 4,
    parameter int IN_W   = 8,
    parameter int COEF_W = 20,
    parameter int ALW    = 4,
    parameter int OUT_W  = 39
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                cload_i,
    input  logic [$clog2(N_GRP)+GRP_SZ-1:0]     caddr_i,
    input  logic [COEF_W-1:0]                   cin_i,
    input  logic                                in_valid_i,
    output logic                                in_ready_o,
    input  logic [N_GRP*GRP_SZ*IN_W-1:0]        in_data_i,
    input  logic                                signed_mode_i,
    input  logic [ALW-1:0]                      acc_len_i,
    output logic                                out_valid_o,
    output logic [OUT_W-1:0]                    out_data_o,
    output logic                                out_sat_o
);
    localparam int CAW   = $clog2(N_GRP) + GRP_SZ;
    localparam int DW    = N_GRP * GRP_SZ * IN_W;
    localparam int ACC_W = COEF_W + $clog2(N_GRP) + IN_W + ALW + 1;
    localparam int BW    = IN_W > 1 ? $clog2(IN_W) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                   state_q, state_d;
    logic signed [COEF_W-1:0] lut_q [2**CAW];
    logic [DW-1:0]            data_q, data_d, sh;
    logic                     sgn_q, sgn_d;
    logic [ALW-1:0]           len_q, len_d, setcnt_q, setcnt_d;
    logic [BW-1:0]            bitcnt_q, bitcnt_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, acc_n, p, term;
    logic [OUT_W-1:0]         out_data_q, out_data_d, res;
    logic                     out_sat_q, out_sat_d, sat;
    logic [GRP_SZ-1:0]        a;
    logic                     last;

    assign last        = bitcnt_q == BW'(IN_W - 1);
    assign in_ready_o  = state_q == IDLE && !cload_i;
    assign out_valid_o = state_q == DONE;
    assign out_data_o  = out_data_q;
    assign out_sat_o   = out_sat_q;
    assign sh          = data_q >> bitcnt_q;
    assign term        = p <<< bitcnt_q;
    // The sign bit of a two's complement sample carries negative weight.
    assign acc_n       = (last && sgn_q) ? acc_q - term : acc_q + term;

    always_comb begin
        p = '0;
        a = '0;
        for (int g = 0; g < N_GRP; g++) begin
            for (int b = 0; b < GRP_SZ; b++) a[b] = sh[(g * GRP_SZ + b) * IN_W];
            p = p + ACC_W'(lut_q[CAW'(g << GRP_SZ) | CAW'(a)]);
        end
    end

`ifdef DA_SAT_EN
    localparam int XW = (ACC_W > OUT_W ? ACC_W : OUT_W) + 1;
    localparam logic signed [XW-1:0] OMAX = (XW'(1) <<< (OUT_W - 1)) - XW'(1);
    localparam logic signed [XW-1:0] OMIN = ~OMAX;
    logic signed [XW-1:0] ax;
    assign ax  = XW'(acc_n);
    assign sat = ax > OMAX || ax < OMIN;
    assign res = ax > OMAX ? OMAX[OUT_W-1:0] : ax < OMIN ? OMIN[OUT_W-1:0] : ax[OUT_W-1:0];
`else
    assign sat = 1'b0;
    assign res = OUT_W'(acc_n);
`endif

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sgn_d      = sgn_q;
        len_d      = len_q;
        setcnt_d   = setcnt_q;
        bitcnt_d   = bitcnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        case (state_q)
            IDLE: if (in_valid_i && in_ready_o) begin
                state_d  = SHIFT;
                data_d   = in_data_i;
                sgn_d    = signed_mode_i;
                bitcnt_d = '0;
                len_d    = setcnt_q == '0 ? acc_len_i : len_q;
            end
            SHIFT: begin
                acc_d    = acc_n;
                bitcnt_d = last ? '0 : bitcnt_q + 1'b1;
                if (last && setcnt_q == len_q) begin
                    state_d    = DONE;
                    out_data_d = res;
                    out_sat_d  = sat;
                end else if (last) begin
                    state_d  = IDLE;
                    setcnt_d = setcnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                acc_d    = '0;
                setcnt_d = '0;
            end
        endcase
    end

    // Coefficients survive reset.
    always_ff @(posedge clk_i) begin
        if (cload_i && state_q == IDLE) lut_q[caddr_i] <= cin_i;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            data_q     <= '0;
            sgn_q      <= 1'b0;
            len_q      <= '0;
            setcnt_q   <= '0;
            bitcnt_q   <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            sgn_q      <= sgn_d;
            len_q      <= len_d;
            setcnt_q   <= setcnt_d;
            bitcnt_q   <= bitcnt_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end
endmodule

// File: tb/tb_da_acc_engine.sv
// tb_da_acc_engine: scoreboard bench for da_acc_engine; linear LUTs make each result a plain dot product of coefficients and samples.
module tb_da_acc_engine;
    localparam int OW = 16;

    logic          clk = 1'b0, reset = 1'b1, cload = 1'b0, in_valid = 1'b0, signed_mode = 1'b0;
    logic [4:0]    caddr = '0;
    logic [19:0]   cin = '0;
    logic [63:0]   in_data = '0;
    logic [3:0]    acc_len = '0;
    logic          in_ready, out_valid, out_sat;
    logic [OW-1:0] out_data;

    typedef struct {logic [OW-1:0] d; logic s;} exp_t;
    exp_t        exp_q[$];
    exp_t        e_m;
    int          vectors = 0, miscompares = 0;
    int          h[2][4];
    longint      acc_m;
    logic [63:0] rd;
    bit          rs;
    int          rn, t_m;

    localparam logic [63:0] X39 = 64'h0000_0000_281E_140A;

    always #5 clk = ~clk;

    da_acc_engine #(.OUT_W(OW)) dut (
        .clk_i(clk), .reset_i(reset), .cload_i(cload), .caddr_i(caddr), .cin_i(cin),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .signed_mode_i(signed_mode), .acc_len_i(acc_len), .out_valid_o(out_valid),
        .out_data_o(out_data), .out_sat_o(out_sat)
    );

    function automatic exp_t shape(input longint v);
        exp_t   e;
        longint mx, mn;
        mx  = (longint'(1) <<< (OW - 1)) - 1;
        mn  = -mx - 1;
        e.s = 1'b0;
        e.d = v[OW-1:0];
`ifdef DA_SAT_EN
        if (v > mx) begin e.s = 1'b1; e.d = mx[OW-1:0]; end
        else if (v < mn) begin e.s = 1'b1; e.d = mn[OW-1:0]; end
`endif
        return e;
    endfunction

    function automatic longint set_val(input logic [63:0] d, input bit s);
        longint t;
        logic [7:0] b;
        t = 0;
        for (int i = 0; i < 8; i++) begin
            b = d[i*8 +: 8];
            t += longint'(h[i/4][i%4]) * (s ? longint'($signed(b)) : longint'(b));
        end
        return t;
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic wait_ready();
        int t;
        t = 0;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        if (!in_ready) check("in_ready timeout", 0, 1);
    endtask

    task automatic load_raw(input int addr, input int v);
        cload = 1'b1; caddr = addr[4:0]; cin = v[19:0];
        @(posedge clk); #1;
        cload = 1'b0;
    endtask

    task automatic load_grp(input int g);
        int v;
        wait_ready();
        for (int a = 0; a < 16; a++) begin
            v = 0;
            for (int j = 0; j < 4; j++) if (a[j]) v += h[g][j];
            load_raw(g * 16 + a, v);
        end
    endtask

    // Inputs are scrambled right after acceptance; the engine must ignore them.
    task automatic send(input logic [63:0] d, input bit s, input logic [3:0] len);
        wait_ready();
        in_data = d; signed_mode = s; acc_len = len; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {$urandom, $urandom}; signed_mode = 1'($urandom); acc_len = 4'($urandom);
    endtask

    always @(negedge clk) if (out_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected out_valid: got data %0d sat %0b, want no result", $signed(out_data), out_sat);
        end else begin
            e_m = exp_q.pop_front();
            if (out_data !== e_m.d || out_sat !== e_m.s) begin
                miscompares++;
                $display("FAIL result: got %0d sat %0b want %0d sat %0b", $signed(out_data), out_sat, $signed(e_m.d), e_m.s);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset out_data", out_data, 0);
        check("reset out_sat", out_sat, 0);

        // LUT0[a] = a[0]: x0 = 0xFF signed and unsigned
        h = '{'{1, 0, 0, 0}, '{0, 0, 0, 0}};
        load_grp(0); load_grp(1);
        exp_q.push_back(shape(-1));
        send(64'hFF, 1'b1, 4'd0);
        exp_q.push_back(shape(255));
        send(64'hFF, 1'b0, 4'd0);

        // h = (1,2,3,4), x = (10,20,30,40) with latency check
        h[0] = '{1, 2, 3, 4};
        load_grp(0);
        exp_q.push_back(shape(300));
        send(X39, 1'b0, 4'd0);
        repeat (7) @(posedge clk);
        #1 check("latency early", out_valid, 0);
        @(posedge clk);
        #1 check("latency on time", out_valid, 1);

        // four sets into one result; acc_len is only taken from the first set
        send(X39, 1'b0, 4'd3);
        send(X39, 1'b0, 4'd0);
        send(X39, 1'b0, 4'd0);
        exp_q.push_back(shape(1200));
        send(X39, 1'b0, 4'd0);

        // reset in the fourth SHIFT cycle discards the set
        send(X39, 1'b0, 4'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("in_ready after abort", in_ready, 1);
        check("out_data after abort", out_data, 0);
        repeat (12) @(posedge clk);
        #1 exp_q.push_back(shape(300));
        send(X39, 1'b0, 4'd0);

        // coefficient writes during SHIFT are dropped
        exp_q.push_back(shape(300));
        send(X39, 1'b0, 4'd0);
        cload = 1'b1; caddr = 5'd0; cin = 20'd999;
        repeat (3) @(posedge clk);
        #1 cload = 1'b0;
        exp_q.push_back(shape(300));
        send(X39, 1'b0, 4'd0);

        for (int r = 0; r < 24; r++) begin
            if (r % 3 == 0) begin
                for (int g = 0; g < 2; g++)
                    for (int j = 0; j < 4; j++) h[g][j] = int'($urandom_range(0, 131070)) - 65535;
                load_grp(0); load_grp(1);
            end
            rn = int'($urandom_range(0, 3));
            acc_m = 0;
            for (int k = 0; k <= rn; k++) begin
                rd = {$urandom, $urandom};
                rs = 1'($urandom);
                acc_m += set_val(rd, rs);
                if (k == rn) exp_q.push_back(shape(acc_m));
                send(rd, rs, k == 0 ? rn[3:0] : 4'($urandom));
            end
        end

        // every LUT entry at full scale, all inputs 255
        wait_ready();
        for (int a = 0; a < 32; a++) load_raw(a, 524287);
        exp_q.push_back(shape(longint'(2) * 524287 * 255));
        send({64{1'b1}}, 1'b0, 4'd0);

        t_m = 0;
        while (exp_q.size() != 0 && t_m < 200) begin @(posedge clk); t_m++; end
        repeat (3) @(posedge clk);
        check("pending results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
